// File: rtl/register_chain.sv
// register_chain: DEPTH-stage, WIDTH-bit register chain with SHIFT, ROTATE,
// COUNT and HOLD operations, a saturating fill counter and a full flag.
// All state is registered; the outputs are plain views of that state.
module register_chain #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           clear_i,
    input  logic                           en_i,
    input  logic [1:0]                     mode_i,
    input  logic [WIDTH-1:0]               data_i,
    output logic [DEPTH*WIDTH-1:0]         stages_o,
    output logic [WIDTH-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0]     fill_o,
    output logic                           valid_o
);

    localparam int FILL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t             mode;
    logic [WIDTH-1:0]  stage [DEPTH];
    logic [FILL_W-1:0] fill;

    assign mode = mode_t'(mode_i);

    // Fill count grows by one per loaded value and sticks at DEPTH.
    function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
        if (f == FILL_W'(DEPTH)) begin
            return f;
        end
        return f + FILL_W'(1);
    endfunction

    // Stage-0 counter wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] count_wrap_inc(input logic [WIDTH-1:0] v);
        return v + WIDTH'(1);
    endfunction

    // Chain and fill update: reset, then clear, then enabled operation.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            fill <= '0;
        end else if (en_i && (mode != MODE_HOLD)) begin
            // Every stage k>0 takes the pre-edge value of stage k-1.
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
            case (mode)
                MODE_SHIFT: begin
                    stage[0] <= data_i;
                    fill     <= fill_sat_inc(fill);
                end
                MODE_ROTATE: begin
                    stage[0] <= stage[DEPTH-1];
                end
                MODE_COUNT: begin
                    stage[0] <= count_wrap_inc(stage[0]);
                    fill     <= fill_sat_inc(fill);
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the stages onto the output bus, stage k at [k*WIDTH +: WIDTH].
    always_comb begin
        stages_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stages_o[k*WIDTH +: WIDTH] = stage[k];
        end
    end

    assign data_o  = stage[DEPTH-1];
    assign fill_o  = fill;
    assign valid_o = (fill == FILL_W'(DEPTH));

endmodule

// File: tb/tb_register_chain.sv
// Bench for register_chain (WIDTH=4, DEPTH=3): directed stimulus, a queue-based
// reference of the chain compared every cycle, plus literal expectations.
module tb_register_chain;

    localparam int W = 4;
    localparam int D = 3;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             en_i = 1'b0;
    logic [1:0]       mode_i = 2'b00;
    logic [W-1:0]     data_i = '0;
    logic [D*W-1:0]   stages_o;
    logic [W-1:0]     data_o;
    logic [1:0]       fill_o;
    logic             valid_o;

    int checks = 0;
    int errors = 0;

    int m_chain[$];
    int m_fill = 0;
    bit model_ok = 1'b0;

    localparam logic [1:0] SH = 2'b00, RO = 2'b01, CN = 2'b10, HO = 2'b11;

    register_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear_i), .en_i(en_i),
        .mode_i(mode_i), .data_i(data_i), .stages_o(stages_o), .data_o(data_o),
        .fill_o(fill_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [D*W-1:0] m_pack();
        logic [D*W-1:0] p;
        p = '0;
        for (int k = 0; k < D; k++) p[k*W +: W] = W'(m_chain[k]);
        return p;
    endfunction

    // Reference: the chain is a queue with stage 0 at the front.
    task automatic model_update(input bit r, input bit c, input bit e,
                                input logic [1:0] m, input logic [3:0] d);
        if (r || c) begin
            m_chain = '{0, 0, 0};
            m_fill = 0;
            if (r) model_ok = 1'b1;
        end else if (e && m != HO) begin
            int nxt;
            case (m)
                SH: nxt = int'(d);
                RO: nxt = m_chain[D-1];
                default: nxt = (m_chain[0] + 1) % (1 << W);
            endcase
            void'(m_chain.pop_back());
            m_chain.push_front(nxt);
            if (m != RO && m_fill < D) m_fill++;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit e,
                        input logic [1:0] m, input logic [3:0] d);
        reset_i = r; clear_i = c; en_i = e; mode_i = m; data_i = d;
        @(posedge clk_i);
        model_update(r, c, e, m, d);
        #1;
    endtask

    // Per-cycle comparison against the reference.
    always @(negedge clk_i) begin
        if (model_ok) begin
            chk("cyc_stages", 32'(stages_o), 32'(m_pack()));
            chk("cyc_data",   32'(data_o),   32'(m_chain[D-1]));
            chk("cyc_fill",   32'(fill_o),   32'(m_fill));
            chk("cyc_valid",  32'(valid_o),  32'(m_fill == D));
        end
    end

    initial begin
        // Reset two cycles.
        step(1, 0, 0, SH, 0);
        step(1, 0, 0, SH, 0);
        chk("rst_stages", 32'(stages_o), 32'h000);
        chk("rst_fill", 32'(fill_o), 0);
        chk("rst_valid", 32'(valid_o), 0);

        // SHIFT 1,2,3.
        step(0, 0, 1, SH, 1);
        chk("sh1_stages", 32'(stages_o), 32'h001);
        chk("sh1_fill", 32'(fill_o), 1);
        step(0, 0, 1, SH, 2);
        chk("sh2_stages", 32'(stages_o), 32'h012);
        chk("sh2_valid", 32'(valid_o), 0);
        step(0, 0, 1, SH, 3);
        chk("sh3_stages", 32'(stages_o), 32'h123);
        chk("sh3_model", 32'(m_pack()), 32'h123);
        chk("sh3_fill", 32'(fill_o), 3);
        chk("sh3_valid", 32'(valid_o), 1);
        chk("sh3_data", 32'(data_o), 1);

        // ROTATE three times returns to the start.
        step(0, 0, 1, RO, 0);
        chk("ro1_stages", 32'(stages_o), 32'h231);
        step(0, 0, 1, RO, 0);
        chk("ro2_stages", 32'(stages_o), 32'h312);
        step(0, 0, 1, RO, 0);
        chk("ro3_stages", 32'(stages_o), 32'h123);
        chk("ro3_fill", 32'(fill_o), 3);

        // HOLD with en, SHIFT without en: no change.
        step(0, 0, 1, HO, 7);
        step(0, 0, 1, HO, 7);
        step(0, 0, 0, SH, 7);
        step(0, 0, 0, SH, 7);
        chk("hold_stages", 32'(stages_o), 32'h123);
        chk("hold_fill", 32'(fill_o), 3);

        // Clear overrides an enabled SHIFT.
        step(0, 1, 1, SH, 9);
        chk("clr_stages", 32'(stages_o), 32'h000);
        chk("clr_fill", 32'(fill_o), 0);
        chk("clr_valid", 32'(valid_o), 0);

        // COUNT 17 cycles after reset: s0 wraps 15 -> 0.
        step(1, 0, 0, SH, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 1, CN, 0);
        chk("cnt17_stages", 32'(stages_o), 32'hF01);
        chk("cnt17_model", 32'(m_pack()), 32'hF01);
        chk("cnt17_fill", 32'(fill_o), 3);

        // Reset mid-COUNT at (5,4,3), then one COUNT.
        step(1, 0, 0, SH, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, CN, 0);
        chk("cnt5_stages", 32'(stages_o), 32'h345);
        step(1, 0, 1, CN, 0);
        chk("midrst_stages", 32'(stages_o), 32'h000);
        chk("midrst_fill", 32'(fill_o), 0);
        step(0, 0, 1, CN, 0);
        chk("postrst_stages", 32'(stages_o), 32'h001);
        chk("postrst_fill", 32'(fill_o), 1);

        // Mixed modes back to back, enable gaps, clear and reset priority.
        step(0, 0, 1, SH, 4'hA);
        step(0, 0, 1, CN, 0);
        step(0, 0, 0, CN, 0);
        step(0, 0, 1, RO, 0);
        step(0, 0, 1, SH, 4'h5);
        step(0, 0, 1, HO, 4'h6);
        step(0, 0, 1, CN, 0);
        step(0, 0, 1, RO, 0);
        step(0, 0, 1, SH, 4'hF);
        step(0, 0, 1, CN, 0);
        step(1, 1, 1, SH, 4'h8);
        step(0, 0, 1, RO, 0);
        step(0, 0, 1, SH, 4'hC);
        step(0, 1, 0, HO, 0);
        step(0, 0, 1, SH, 4'h3);
        step(0, 0, 1, SH, 4'h4);
        step(0, 0, 1, SH, 4'h5);
        chk("mix_data", 32'(data_o), 32'h3);
        chk("mix_valid", 32'(valid_o), 1);

        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
